imm_ext_pipe: RTL
=================

# imm_ext_pipe

Parametrised, pipelined immediate-extension unit replacing the fixed 13→16-bit sign extender in the decode stage. It widens an IN_W-bit immediate to OUT_W bits in one of four modes. It supports a prefix beat that supplies the upper immediate bits for the following beat, and registers its result behind a valid/ready handshake so decode can stall it.

## Interface
- IN_W, default 13: immediate field width; must satisfy 2 ≤ IN_W < OUT_W.
- OUT_W, default 16: datapath word width.
- PFX_W, derived = OUT_W − IN_W (localparam): prefix width, 3 at defaults.

Ports:
- clk  in  1  rising-edge clock, single domain.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; drops the held prefix and the output register.
- in_valid  in  1  input beat present.
- in_ready  out  1  unit can accept a beat this cycle.
- in_imm  in  IN_W  raw immediate field.
- in_mode  in  2  extension mode; values are listed under Operation.
- in_pfx  in  1  beat is a prefix; it produces no output.
- out_valid  out  1  out_imm holds a result.
- out_ready  in  1  consumer takes the result.
- out_imm  out  OUT_W  extended immediate.
- out_pfxd  out  1  result was built from a prefix.

## Operation
- Modes, applied to a non-prefixed beat:
  - SEXT (0): sign-extend in_imm.
  - ZEXT (1): zero-extend in_imm.
  - BRANCH (2): sign-extend in_imm, then shift left by 1. Bit OUT_W is dropped; no overflow flag.
  - UPPER (3): out = {in_imm, PFX_W'b0}.
- A beat is accepted when in_valid && in_ready.
- Prefix beat (in_pfx=1):
  - in_imm[PFX_W-1:0] is stored in pfx_reg and the FSM moves to PFX_HELD.
  - Upper in_imm bits and in_mode are ignored.
  - No output is produced and out_valid is unaffected.
- FSM states are IDLE and PFX_HELD.
  - IDLE → PFX_HELD on an accepted prefix beat.
  - PFX_HELD → IDLE on an accepted non-prefix beat or on flush.
  - PFX_HELD → PFX_HELD on another accepted prefix beat, which overwrites pfx_reg with the newest value.
- Non-prefix beat accepted in PFX_HELD:
  - out_imm = {pfx_reg, in_imm}; in_mode is ignored; out_pfxd = 1.
  - pfx_reg is cleared to 0 in the same cycle.
- in_ready = !out_valid || out_ready, so the single output register passes data through when drained.
  - Prefix beats also obey in_ready, which keeps beat ordering strict.
- flush has priority over acceptance:
  - in that cycle no beat is accepted;
  - out_valid, out_pfxd and pfx_reg go to 0;
  - state goes to IDLE.
- Reset values: out_valid=0, out_imm=0, out_pfxd=0, pfx_reg=0, state=IDLE. in_ready=1 combinationally after reset.

## Timing
- Latency is 1 cycle: a result accepted at edge N is visible with out_valid=1 after edge N.
- Throughput is 1 result per cycle when out_ready=1. Each prefix costs one input cycle.
- out_imm and out_pfxd hold stable while out_valid && !out_ready.
- A simultaneous output pop and input accept loads the new result with no bubble.
- in_ready depends combinationally on out_ready. No other combinational path runs from input to output.
- Reset assertion mid-operation clears state immediately, with no clock needed. Deassertion is synchronised externally.

## Structure
- Package imm_ext_pkg holds:
  - enum imm_mode_t (SEXT, ZEXT, BRANCH, UPPER);
  - FSM state enum imm_ext_state_t;
  - a widths-check function used by an elaboration assertion (OUT_W > IN_W).
- Sub-module imm_ext_core: purely combinational mode/prefix mux computing the next out_imm. It is instantiated once.
- The top level holds the FSM, pfx_reg and the output register.

## Test plan
All scenarios use IN_W=13, OUT_W=16, out_ready=1 unless stated.
- Mode sweep:
  - SEXT 13'h1001 → 16'hF001;
  - ZEXT 13'h1001 → 16'h1001;
  - SEXT 13'h0FFF → 16'h0FFF.
  - Each appears 1 cycle after its beat, with out_pfxd=0.
- BRANCH and UPPER:
  - BRANCH 13'h1FFF → 16'hFFFE;
  - BRANCH 13'h0005 → 16'h000A;
  - UPPER 13'h0001 → 16'h0008;
  - UPPER 13'h1FFF → 16'hFFF8.
- Prefix sequence:
  - prefix 13'h0005, then ZEXT 13'h0ABC → 16'hAABC with out_pfxd=1.
  - The next SEXT 13'h1001 → 16'hF001 with out_pfxd=0, showing the prefix was consumed.
- Double prefix: prefix 3'b001, prefix 3'b110, then 13'h0000 → 16'hC000. Exactly one output is produced.
- Backpressure:
  - Hold out_ready=0 with out_valid=1: in_ready=0, and out_imm holds for 5 cycles.
  - Raise out_ready with a new beat pending: the next result appears on the following edge with no bubble.
- Flush and reset:
  - prefix 13'h0007 then flush → next ZEXT 13'h0001 gives 16'h0001 with out_pfxd=0.
  - rst_n low mid-PFX_HELD with out_valid=1 → outputs clear asynchronously, before the next clock edge.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// rtl/imm_ext_pkg.sv - shared types and width check for the immediate extender
package imm_ext_pkg;

  typedef enum logic [1:0] {
    SEXT   = 2'd0,
    ZEXT   = 2'd1,
    BRANCH = 2'd2,
    UPPER  = 2'd3
  } imm_mode_t;

  typedef enum logic {
    IDLE     = 1'b0,
    PFX_HELD = 1'b1
  } imm_ext_state_t;

  function automatic bit widths_ok(input int in_w, input int out_w);
    return (in_w >= 2) && (out_w > in_w);
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// rtl/imm_ext_core.sv - combinational mode/prefix mux producing the next extended immediate
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter  int IN_W  = 13,
  parameter  int OUT_W = 16,
  localparam int PFX_W = OUT_W - IN_W
) (
  input  logic [IN_W-1:0]  i_imm,
  input  imm_mode_t        i_mode,
  input  logic             i_use_pfx,
  input  logic [PFX_W-1:0] i_pfx,
  output logic [OUT_W-1:0] o_imm
);

  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_branch;
  logic [OUT_W-1:0] w_upper;

  assign w_sext   = {{PFX_W{i_imm[IN_W-1]}}, i_imm};
  assign w_zext   = {{PFX_W{1'b0}}, i_imm};
  // The carry out of the shift is simply lost; branch offsets never flag overflow.
  assign w_branch = w_sext << 1;
  assign w_upper  = {i_imm, {PFX_W{1'b0}}};

  always_comb begin
    o_imm = w_sext;
    if (i_use_pfx) begin
      o_imm = {i_pfx, i_imm};
    end else begin
      case (i_mode)
        SEXT:   o_imm = w_sext;
        ZEXT:   o_imm = w_zext;
        BRANCH: o_imm = w_branch;
        UPPER:  o_imm = w_upper;
      endcase
    end
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - pipelined immediate extender with prefix beat and output handshake
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 13,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic             in_pfx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic             out_pfxd
);

  localparam int PFX_W = OUT_W - IN_W;

  generate
    if (!widths_ok(IN_W, OUT_W)) begin : g_bad_widths
      $error("imm_ext_pipe: widths must satisfy 2 <= IN_W < OUT_W");
    end
  endgenerate

  imm_ext_state_t   r_state;
  imm_ext_state_t   w_state_nxt;
  logic [PFX_W-1:0] r_pfx;
  logic             r_out_valid;
  logic             r_out_pfxd;
  logic [OUT_W-1:0] r_out_imm;
  logic [OUT_W-1:0] w_core_imm;
  logic             w_in_ready;
  logic             w_use_pfx;
  logic             w_accept;
  logic             w_accept_pfx;
  logic             w_accept_data;

  // Flush wins over acceptance so a dropped prefix can never pair with a live beat.
  assign w_accept      = in_valid && w_in_ready && !flush;
  assign w_accept_pfx  = w_accept && in_pfx;
  assign w_accept_data = w_accept && !in_pfx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else if (w_accept_pfx) begin
      w_state_nxt = PFX_HELD;
    end else if (w_accept_data) begin
      w_state_nxt = IDLE;
    end
  end

  always_comb begin
    w_in_ready = !r_out_valid || out_ready;
    w_use_pfx  = (r_state == PFX_HELD);
  end

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .i_imm     (in_imm),
    .i_mode    (imm_mode_t'(in_mode)),
    .i_use_pfx (w_use_pfx),
    .i_pfx     (r_pfx),
    .o_imm     (w_core_imm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pfx <= '0;
    end else if (flush) begin
      r_pfx <= '0;
    end else if (w_accept_pfx) begin
      r_pfx <= in_imm[PFX_W-1:0];
    end else if (w_accept_data) begin
      r_pfx <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_imm   <= '0;
      r_out_pfxd  <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_pfxd  <= 1'b0;
    end else if (w_accept_data) begin
      r_out_valid <= 1'b1;
      r_out_imm   <= w_core_imm;
      r_out_pfxd  <= w_use_pfx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_imm   = r_out_imm;
  assign out_pfxd  = r_out_pfxd;

endmodule
